// File: rtl/adder_arb_pkg.sv
// Shared constants, pointer helper and response record for the adder arbiter.
package adder_arb_pkg;

  localparam int NUM_REQ_DEFAULT = 32'd4;
  localparam int WIDTH_DEFAULT   = 32'd32;
  localparam int RESP_ID_W       = $clog2(NUM_REQ_DEFAULT);

  typedef struct packed {
    logic [RESP_ID_W-1:0]     id;
    logic                     cout;
    logic [WIDTH_DEFAULT-1:0] y;
  } resp_t;

  // Next round-robin position after ptr, wrapping at n.
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/adder.sv
// Existing combinational adder used as the shared datapath.
module adder #(
  parameter int WIDTH = 32'd32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a + b;

endmodule

// File: rtl/adder_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int N  = 32'd4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_grant
);

  // Scan N positions starting at ptr; the first hit wins.
  always_comb begin
    int   idx_s;
    logic hit_s;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    idx_s     = 32'd0;
    hit_s     = 1'b0;
    for (int k = 0; k < N; k++) begin
      idx_s            = (int'(ptr) + k) % N;
      hit_s            = !any_grant && req[idx_s];
      grant[idx_s]     = hit_s;
      grant_idx        = hit_s ? IW'(idx_s) : grant_idx;
      any_grant        = any_grant | hit_s;
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin time-sharing of one adder among NUM_REQ requesters, with a
// single registered, tagged response channel that supports backpressure.
module adder_arbiter
  import adder_arb_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEFAULT,
  parameter int WIDTH   = WIDTH_DEFAULT,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [ID_W-1:0]          resp_id,
  output logic [WIDTH-1:0]         resp_y,
  output logic                     resp_cout,
  input  logic                     resp_ready
);

  if (NUM_REQ != NUM_REQ_DEFAULT || WIDTH != WIDTH_DEFAULT) begin : g_cfg_check
    $error("adder_arbiter: resp_t is sized for the package default configuration");
  end

  logic               can_accept_s;
  logic [NUM_REQ-1:0] req_elig_s;
  logic [NUM_REQ-1:0] gnt_s;
  logic [ID_W-1:0]    gnt_idx_s;
  logic               any_gnt_s;
  logic [WIDTH-1:0]   a_sel_s;
  logic [WIDTH-1:0]   b_sel_s;
  logic [WIDTH-1:0]   sum_s;
  logic               cout_s;
  logic [ID_W-1:0]    rr_ptr_r;
  logic               resp_valid_r;
  resp_t              resp_r;

  // Grant depends only on req_valid and the response slot state, never on req_ready.
  assign can_accept_s = !resp_valid_r || resp_ready;
  assign req_elig_s   = req_valid & {NUM_REQ{can_accept_s}};

  rr_picker #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_picker (
    .req       (req_elig_s),
    .ptr       (rr_ptr_r),
    .grant     (gnt_s),
    .grant_idx (gnt_idx_s),
    .any_grant (any_gnt_s)
  );

  assign req_ready = gnt_s;
  assign a_sel_s   = req_a[int'(gnt_idx_s)*WIDTH +: WIDTH];
  assign b_sel_s   = req_b[int'(gnt_idx_s)*WIDTH +: WIDTH];

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a (a_sel_s),
    .b (b_sel_s),
    .y (sum_s)
  );

  // Carry out of the MSB recovered from the operand and sum sign bits.
  assign cout_s = (a_sel_s[WIDTH-1] & b_sel_s[WIDTH-1]) |
                  ((a_sel_s[WIDTH-1] | b_sel_s[WIDTH-1]) & ~sum_s[WIDTH-1]);

  // Response register and round-robin pointer; a new result may overwrite a draining one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_r       <= '0;
      rr_ptr_r     <= '0;
    end else if (any_gnt_s) begin
      resp_valid_r <= 1'b1;
      resp_r.id    <= gnt_idx_s;
      resp_r.cout  <= cout_s;
      resp_r.y     <= sum_s;
      rr_ptr_r     <= ID_W'(rr_next(32'(gnt_idx_s), 32'(NUM_REQ)));
    end else if (resp_ready) begin
      resp_valid_r <= 1'b0;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_id    = resp_r.id;
  assign resp_y     = resp_r.y;
  assign resp_cout  = resp_r.cout;

endmodule

// File: tb/tb_adder_arbiter.sv
// Randomised and directed bench for adder_arbiter with a queue scoreboard.
module tb_adder_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int IW = 2;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_a, req_b;
  logic [N-1:0]   req_ready;
  logic           resp_valid;
  logic [IW-1:0]  resp_id;
  logic [W-1:0]   resp_y;
  logic           resp_cout;
  logic           resp_ready;

  adder_arbiter dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .resp_valid(resp_valid), .resp_id(resp_id),
    .resp_y(resp_y), .resp_cout(resp_cout), .resp_ready(resp_ready)
  );

  always #5 clk = ~clk;

  typedef struct { int id; logic [W:0] sum; } exp_t;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  int   grant_log[$];
  int   issued[N];
  int   accepted[N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: resp slot occupancy, rotating priority start, fairness counters.
  int         model_ptr = 0;
  bit         model_valid = 0;
  int         waits[N];
  bit         stall_prev = 0;
  logic [W-1:0]  y_prev;
  logic [IW-1:0] id_prev;
  logic          c_prev;

  always @(negedge clk) begin
    exp_t       e;
    int         g;
    logic [N-1:0] exp_ready;
    if (reset) begin
      model_ptr = 0; model_valid = 0; stall_prev = 0;
      sb.delete();
      for (int i = 0; i < N; i++) waits[i] = 0;
    end else begin
      chk("resp_valid", 64'(resp_valid), 64'(model_valid));
      if (stall_prev) begin
        chk("stall_y", 64'(resp_y), 64'(y_prev));
        chk("stall_id", 64'(resp_id), 64'(id_prev));
        chk("stall_cout", 64'(resp_cout), 64'(c_prev));
      end
      g = -1;
      if (!model_valid || resp_ready)
        for (int k = 0; k < N; k++)
          if (g < 0 && req_valid[(model_ptr + k) % N]) g = (model_ptr + k) % N;
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("req_ready", 64'(req_ready), 64'(exp_ready));
      if (model_valid && resp_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          chk("resp_id", 64'(resp_id), 64'(e.id));
          chk("resp_y", 64'(resp_y), 64'(e.sum[W-1:0]));
          chk("resp_cout", 64'(resp_cout), 64'(e.sum[W]));
        end
      end
      stall_prev = model_valid && !resp_ready;
      y_prev = resp_y; id_prev = resp_id; c_prev = resp_cout;
      if (g >= 0) begin
        e.id  = g;
        e.sum = {1'b0, req_a[g*W +: W]} + {1'b0, req_b[g*W +: W]};
        sb.push_back(e);
        chk("fairness", 64'(waits[g] < N), 64'(1));
        for (int i = 0; i < N; i++) waits[i] = (i != g && req_valid[i]) ? waits[i] + 1 : 0;
        accepted[g]++;
        grant_log.push_back(g);
        model_ptr   = (g + 1) % N;
        model_valid = 1;
      end else if (resp_ready) begin
        model_valid = 0;
      end
    end
  end

  function automatic bit pending(input int i);
    return issued[i] != accepted[i];
  endfunction

  task automatic issue(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
    req_valid[i]    = 1'b1;
    issued[i]++;
  endtask

  task automatic step();
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (!pending(i)) req_valid[i] = 1'b0;
  endtask

  task automatic drain();
    int k;
    bit any;
    k = 0;
    any = 1;
    while (any && k < 60) begin
      any = 0;
      for (int i = 0; i < N; i++) any |= pending(i);
      if (any) step();
      k++;
    end
    chk("drain_timeout", 64'(any), 64'(0));
  endtask

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 3))
      0:       return '1;
      1:       return '0;
      default: return W'($urandom);
    endcase
  endfunction

  logic [W-1:0] arith_a[3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0000_0000};
  logic [W-1:0] arith_b[3] = '{32'h5EFF_FFFF, 32'hFFFF_FFFA, 32'h0000_0005};
  logic [W-1:0] arith_y[3] = '{32'h5EFF_FFFE, 32'hFFFF_FFF5, 32'h0000_0005};
  logic         arith_c[3] = '{1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; resp_ready = 1'b0;
    for (int i = 0; i < N; i++) begin issued[i] = 0; accepted[i] = 0; end
    step(); step();
    chk("rst_valid", 64'(resp_valid), 64'(0));
    chk("rst_y", 64'(resp_y), 64'(0));
    chk("rst_id", 64'(resp_id), 64'(0));
    chk("rst_cout", 64'(resp_cout), 64'(0));
    reset = 1'b0;
    step();

    // Round robin with every requester continuously valid.
    resp_ready = 1'b1;
    grant_log.delete();
    for (int c = 0; c < 5; c++) begin
      for (int i = 0; i < N; i++) if (!pending(i)) issue(i, W'(i), 32'd10);
      step();
    end
    for (int c = 0; c < 5; c++) chk("rr_order", 64'(grant_log[c]), 64'(c % N));
    drain();

    // Skip and wrap: lone grant to 3, then 1 and 2, then 0 and 3.
    grant_log.delete();
    issue(3, 32'd1, 32'd2); step();
    issue(1, 32'd3, 32'd4); issue(2, 32'd5, 32'd6); drain();
    issue(0, 32'd7, 32'd8); issue(3, 32'd9, 32'd9); drain();
    chk("skip_first", 64'(grant_log[1]), 64'(1));
    chk("skip_second", 64'(grant_log[2]), 64'(2));
    chk("wrap_from3", 64'(grant_log[3]), 64'(3));
    chk("wrap_then0", 64'(grant_log[4]), 64'(0));
    step();

    // Backpressure: stalled result blocks req2, then drain and grant overlap.
    issue(1, 32'd100, 32'd23); step();
    resp_ready = 1'b0;
    issue(2, 32'd7, 32'd8);
    for (int c = 0; c < 3; c++) begin
      step();
      chk("bp_ready", 64'(req_ready), 64'(0));
    end
    resp_ready = 1'b1;
    step();
    @(negedge clk);
    chk("bp_b2b_valid", 64'(resp_valid), 64'(1));
    chk("bp_b2b_id", 64'(resp_id), 64'(2));
    chk("bp_b2b_y", 64'(resp_y), 64'(15));

    // Arithmetic boundaries.
    for (int t = 0; t < 3; t++) begin
      step();
      issue(0, arith_a[t], arith_b[t]);
      step();
      @(negedge clk);
      chk("arith_y", 64'(resp_y), 64'(arith_y[t]));
      chk("arith_cout", 64'(resp_cout), 64'(arith_c[t]));
    end

    // Asynchronous reset while a result is held.
    step();
    resp_ready = 1'b0;
    issue(1, 32'd50, 32'd50);
    step(); step();
    #2 reset = 1'b1;
    #1;
    chk("arst_valid", 64'(resp_valid), 64'(0));
    chk("arst_y", 64'(resp_y), 64'(0));
    chk("arst_id", 64'(resp_id), 64'(0));
    req_valid = '0;
    for (int i = 0; i < N; i++) issued[i] = accepted[i];
    resp_ready = 1'b1;
    step(); step();
    reset = 1'b0;
    step();
    issue(0, 32'd4, 32'd3); issue(2, 32'd1, 32'd1);
    step();
    @(negedge clk);
    chk("post_rst_valid", 64'(resp_valid), 64'(1));
    chk("post_rst_id", 64'(resp_id), 64'(0));
    chk("post_rst_y", 64'(resp_y), 64'(7));
    drain();

    // Random traffic with random backpressure.
    for (int c = 0; c < 10000; c++) begin
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++)
        if (!pending(i) && $urandom_range(0, 1) == 1) issue(i, rand_op(), rand_op());
      step();
    end
    resp_ready = 1'b1;
    drain();
    step(); step();
    chk("sb_leftover", 64'(sb.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
